// File: rtl/easyaxi_slv_if.sv
// AR/R channel bundle between the EasyAXI master and the read-side responder.
// Single-beat reads: no ID, burst or last signalling.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

interface easyaxi_slv_if #(
  parameter int unsigned ADDR_WIDTH = `AXI_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  axi_slv_arvalid;
  logic                  axi_slv_arready;
  logic [ADDR_WIDTH-1:0] axi_slv_araddr;
  logic                  axi_slv_rvalid;
  logic                  axi_slv_rready;
  logic [DATA_WIDTH-1:0] axi_slv_rdata;
  logic [1:0]            axi_slv_rresp;

  modport master (
    output axi_slv_arvalid,
    output axi_slv_araddr,
    output axi_slv_rready,
    input  axi_slv_arready,
    input  axi_slv_rvalid,
    input  axi_slv_rdata,
    input  axi_slv_rresp
  );

  modport slave (
    input  axi_slv_arvalid,
    input  axi_slv_araddr,
    input  axi_slv_rready,
    output axi_slv_arready,
    output axi_slv_rvalid,
    output axi_slv_rdata,
    output axi_slv_rresp
  );
endinterface

// File: rtl/easyaxi_slv.sv
// AXI read responder: queues AR addresses in order and returns one R beat per
// request after a fixed wait, flagging out-of-range addresses with SLVERR.
`ifndef AXI_ADDR_WIDTH
`define AXI_ADDR_WIDTH 32
`endif

module easyaxi_slv #(
  parameter int unsigned           ADDR_WIDTH   = `AXI_ADDR_WIDTH,
  parameter int unsigned           DATA_WIDTH   = 32,
  parameter int unsigned           DEPTH        = 4,
  parameter int unsigned           READ_LAT     = 2,
  parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT   = 32'h0000_1000,
  parameter logic [DATA_WIDTH-1:0] DATA_PATTERN = 32'hA5A5_0000
) (
  input  logic         clk,
  input  logic         rst,
  easyaxi_slv_if.slave axi_slv
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned LAT_W = (READ_LAT > 1) ? $clog2(READ_LAT) : 1;

  localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(DEPTH);
  localparam logic [LAT_W-1:0] LAT_LOAD_C = LAT_W'(READ_LAT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  logic [ADDR_WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r;
  logic [PTR_W-1:0]      rd_ptr_r;
  logic [CNT_W-1:0]      count_r;

  state_t                state_r;
  state_t                state_nxt_s;
  logic [LAT_W-1:0]      cnt_r;

  logic                  arready_s;
  logic                  push_s;
  logic                  pop_s;
  logic                  rvalid_s;
  logic                  load_s;

  logic [ADDR_WIDTH-1:0] head_s;
  logic [DATA_WIDTH-1:0] addr_ext_s;
  logic [DATA_WIDTH-1:0] rdata_nxt_s;
  logic [1:0]            rresp_nxt_s;
  logic [DATA_WIDTH-1:0] rdata_r;
  logic [1:0]            rresp_r;

  // AR acceptance depends only on occupancy, so a same-cycle pop cannot open a full queue
  always_comb begin
    arready_s = ~rst & (count_r < DEPTH_C);
    push_s    = axi_slv.axi_slv_arvalid & arready_s;
  end

  // Address storage; entries are only meaningful between push and pop
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= axi_slv.axi_slv_araddr;
    end
  end

  // Queue pointers and occupancy
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // FSM next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if (count_r != {CNT_W{1'b0}}) begin
          state_nxt_s = WAIT;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WAIT: begin
        if (cnt_r == {LAT_W{1'b0}}) begin
          state_nxt_s = RESP;
        end else begin
          state_nxt_s = WAIT;
        end
      end
      RESP: begin
        if (axi_slv.axi_slv_rready) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = RESP;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    rvalid_s = 1'b0;
    load_s   = 1'b0;
    case (state_r)
      WAIT:    load_s   = (cnt_r == {LAT_W{1'b0}});
      RESP:    rvalid_s = 1'b1;
      default: begin
        rvalid_s = 1'b0;
        load_s   = 1'b0;
      end
    endcase
    pop_s = rvalid_s & axi_slv.axi_slv_rready;
  end

  // Wait counter: loaded on IDLE->WAIT, counts down to zero in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {LAT_W{1'b0}};
    end else if ((state_r == IDLE) && (state_nxt_s == WAIT)) begin
      cnt_r <= LAT_LOAD_C;
    end else if ((state_r == WAIT) && (cnt_r != {LAT_W{1'b0}})) begin
      cnt_r <= cnt_r - LAT_W'(1);
    end
  end

  // Response value for the queue head; the head cannot move while in WAIT
  always_comb begin
    head_s     = mem_r[rd_ptr_r];
    addr_ext_s = DATA_WIDTH'(head_s);
    if (head_s < ADDR_LIMIT) begin
      rdata_nxt_s = addr_ext_s ^ DATA_PATTERN;
      rresp_nxt_s = 2'b00;
    end else begin
      rdata_nxt_s = {DATA_WIDTH{1'b0}};
      rresp_nxt_s = 2'b10;
    end
  end

  // R payload registers hold stable for the whole RESP state
  always_ff @(posedge clk) begin
    if (rst) begin
      rdata_r <= {DATA_WIDTH{1'b0}};
      rresp_r <= 2'b00;
    end else if (load_s) begin
      rdata_r <= rdata_nxt_s;
      rresp_r <= rresp_nxt_s;
    end
  end

  assign axi_slv.axi_slv_arready = arready_s;
  assign axi_slv.axi_slv_rvalid  = rvalid_s;
  assign axi_slv.axi_slv_rdata   = rdata_r;
  assign axi_slv.axi_slv_rresp   = rresp_r;

endmodule

// File: tb/tb_easyaxi_slv.sv
// Scoreboard bench for easyaxi_slv: AR accepts push expected beats, an
// independent monitor checks data, order, timing, stability and arready.
module tb_easyaxi_slv;
  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LAT = 2;
  localparam int DEP = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  easyaxi_slv_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  easyaxi_slv #(
    .ADDR_WIDTH  (AW),
    .DATA_WIDTH  (DW),
    .DEPTH       (DEP),
    .READ_LAT    (LAT),
    .ADDR_LIMIT  (32'h0000_1000),
    .DATA_PATTERN(32'hA5A5_0000)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .axi_slv(bus.slave)
  );

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
    int          acc;
  } exp_t;

  exp_t        exp_q[$];
  int          checks    = 0;
  int          errors    = 0;
  int          cyc       = 0;
  int          model_cnt = 0;
  int          last_hs   = -1000;
  int          rr_mode   = 0;
  logic        prev_rv    = 1'b0;
  logic        prev_stall = 1'b0;
  logic [31:0] prev_data  = 32'h0;
  logic [1:0]  prev_resp  = 2'b00;

  always @(posedge clk) cyc++;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference: in-range reads return address XOR pattern, others SLVERR with zero data
  function automatic exp_t ref_beat(input logic [31:0] a, input int c);
    exp_t e;
    if (a < 32'h0000_1000) begin
      e.data = a ^ 32'hA5A5_0000;
      e.resp = 2'b00;
    end else begin
      e.data = 32'h0;
      e.resp = 2'b10;
    end
    e.acc = c;
    return e;
  endfunction

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (rst) begin
      chk(bus.axi_slv_arready == 1'b0, "arready_in_reset", {63'h0, bus.axi_slv_arready}, 64'h0);
      exp_q.delete();
      model_cnt  = 0;
      last_hs    = -1000;
      prev_rv    = 1'b0;
      prev_stall = 1'b0;
    end else begin
      chk(bus.axi_slv_arready == (model_cnt < DEP), "arready",
          {63'h0, bus.axi_slv_arready}, {63'h0, (model_cnt < DEP)});
      if (prev_stall) begin
        chk(bus.axi_slv_rvalid == 1'b1, "rvalid_hold", {63'h0, bus.axi_slv_rvalid}, 64'h1);
        chk(bus.axi_slv_rdata == prev_data && bus.axi_slv_rresp == prev_resp, "r_stable",
            {30'h0, bus.axi_slv_rresp, bus.axi_slv_rdata}, {30'h0, prev_resp, prev_data});
      end
      if (bus.axi_slv_rvalid && !prev_rv) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "rvalid_unexpected", 64'h1, 64'h0);
        end else begin
          int due;
          due = ((exp_q[0].acc > last_hs) ? exp_q[0].acc : last_hs) + 2 + LAT;
          chk(cyc == due, "rvalid_latency", 64'(cyc), 64'(due));
        end
      end
      if (bus.axi_slv_rvalid && bus.axi_slv_rready) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "r_beat_unexpected", {32'h0, bus.axi_slv_rdata}, 64'h0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk(bus.axi_slv_rdata == e.data, "rdata", {32'h0, bus.axi_slv_rdata}, {32'h0, e.data});
          chk(bus.axi_slv_rresp == e.resp, "rresp", {62'h0, bus.axi_slv_rresp}, {62'h0, e.resp});
          model_cnt--;
        end
        last_hs = cyc;
      end
      if (bus.axi_slv_arvalid && bus.axi_slv_arready) begin
        exp_q.push_back(ref_beat(bus.axi_slv_araddr, cyc));
        model_cnt++;
      end
      prev_stall = bus.axi_slv_rvalid && !bus.axi_slv_rready;
      prev_rv    = bus.axi_slv_rvalid;
      prev_data  = bus.axi_slv_rdata;
      prev_resp  = bus.axi_slv_rresp;
    end
  end

  // rready driver: 0 = always 1, 1 = always 0, 2 = toggle, 3 = random
  initial begin
    bus.axi_slv_rready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rr_mode)
        0:       bus.axi_slv_rready = 1'b1;
        1:       bus.axi_slv_rready = 1'b0;
        2:       bus.axi_slv_rready = ~bus.axi_slv_rready;
        default: bus.axi_slv_rready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  task automatic send_ar(input logic [31:0] a);
    bit hs;
    hs = 1'b0;
    bus.axi_slv_arvalid = 1'b1;
    bus.axi_slv_araddr  = a;
    for (int t = 0; t < 300; t++) begin
      @(negedge clk);
      if (bus.axi_slv_arready) begin
        hs = 1'b1;
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.axi_slv_arvalid = 1'b0;
    if (!hs) chk(1'b0, "ar_timeout", {32'h0, a}, 64'h1);
  endtask

  task automatic drain();
    for (int t = 0; t < 600; t++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.axi_slv_rvalid) break;
    end
    chk(exp_q.size() == 0 && !bus.axi_slv_rvalid, "drain", 64'(exp_q.size()), 64'h0);
  endtask

  initial begin
    bus.axi_slv_arvalid = 1'b0;
    bus.axi_slv_araddr  = 32'h0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(bus.axi_slv_rvalid == 1'b0, "reset_rvalid", {63'h0, bus.axi_slv_rvalid}, 64'h0);
    chk(bus.axi_slv_rdata == 32'h0, "reset_rdata", {32'h0, bus.axi_slv_rdata}, 64'h0);
    chk(bus.axi_slv_rresp == 2'b00, "reset_rresp", {62'h0, bus.axi_slv_rresp}, 64'h0);
    chk(bus.axi_slv_arready == 1'b1, "reset_arready", {63'h0, bus.axi_slv_arready}, 64'h1);

    // Single read
    rr_mode = 0;
    send_ar(32'h10);
    drain();

    // Fill with master stalled; fifth request is held off
    rr_mode = 1;
    @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) send_ar(32'(i));
    bus.axi_slv_arvalid = 1'b1;
    bus.axi_slv_araddr  = 32'h4;
    repeat (6) begin
      @(negedge clk);
      chk(bus.axi_slv_arready == 1'b0, "full_arready", {63'h0, bus.axi_slv_arready}, 64'h0);
    end
    chk(bus.axi_slv_rvalid == 1'b1 && bus.axi_slv_rdata == 32'hA5A5_0000, "full_head",
        {31'h0, bus.axi_slv_rvalid, bus.axi_slv_rdata}, {31'h0, 1'b1, 32'hA5A5_0000});

    // Pop while full with AR pending: accept only lands the cycle after
    rr_mode = 0;
    begin
      bit got;
      got = 1'b0;
      for (int t = 0; t < 50; t++) begin
        @(negedge clk);
        if (bus.axi_slv_arready) begin
          got = 1'b1;
          break;
        end
      end
      @(posedge clk);
      #1;
      bus.axi_slv_arvalid = 1'b0;
      chk(got, "full_pop_accept", {63'h0, got}, 64'h1);
    end
    drain();

    // Backpressure
    rr_mode = 2;
    for (int i = 0; i < 4; i++) send_ar(32'(i));
    drain();

    // Error and boundary address
    rr_mode = 0;
    send_ar(32'h0000_1000);
    send_ar(32'h0000_0FFF);
    drain();

    // Reset while waiting discards the request
    send_ar(32'h30);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk(bus.axi_slv_arready == 1'b1, "post_reset_arready", {63'h0, bus.axi_slv_arready}, 64'h1);
    repeat (10) @(negedge clk);
    chk(bus.axi_slv_rvalid == 1'b0, "no_beat_after_reset", {63'h0, bus.axi_slv_rvalid}, 64'h0);
    send_ar(32'h20);
    drain();

    // Randomized traffic
    rr_mode = 3;
    for (int n = 0; n < 80; n++) begin
      int gap;
      logic [31:0] a;
      gap = $urandom_range(0, 3);
      repeat (gap) begin
        @(posedge clk);
        #1;
      end
      a = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 32'h1FFF));
      send_ar(a);
    end
    rr_mode = 0;
    drain();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
